mc_control: RTL and testbench

//  Multi-cycle control FSM driving the ALU's aluControl and operand selects, plus PC/IR/memory/regfile enables.

---
 rtl/mc_control_if.sv | 34 +++
 rtl/mc_control.sv | 177 +++++++++++++++++
 tb/tb_mc_control.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_if.sv
// mc_control_if: bundles the decode inputs, memory handshake and datapath
// control outputs of the multi-cycle control FSM.
// master = the controller (mc_control), slave = the datapath / memory side.
interface mc_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       isZero;
    logic       mem_ready;
    logic [5:0] aluControl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;

    modport master (
        input  opcode, funct, isZero, mem_ready,
        output aluControl, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
               mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, illegal
    );

    modport slave (
        output opcode, funct, isZero, mem_ready,
        input  aluControl, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
               mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, illegal
    );
endinterface

// File: rtl/mc_control.sv
// mc_control: multi-cycle control FSM (FETCH..WB) for a small MIPS-like core.
// Outputs are decoded from the current state, with mem_ready (FETCH) and
// isZero (BRANCH) folded in the same cycle.
// Optional feature macro: CTRL_PERF_CNT_EN adds the 'retired' instruction
// counter output and its PERF_W parameter.
module mc_control #(
    parameter int MEM_TIMEOUT = 0
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    mc_control_if.master bus
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] retired
`endif
);

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB, S_BRANCH, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_R, CL_ADDI, CL_ADDIU, CL_LW, CL_SW, CL_BEQ
    } class_t;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t              state_q, state_d;
    class_t              class_q, class_d;
    logic [WAIT_W-1:0]   waitCnt_q, waitCnt_d;
    logic                timeoutHit;
    logic                functOk;

    assign functOk    = (bus.funct[5:2] == 4'b1000);
    assign timeoutHit = (MEM_TIMEOUT != 0) && (int'(waitCnt_q) >= MEM_TIMEOUT - 1);

    // Next state, instruction-class latch and memory wait counter
    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        waitCnt_d = waitCnt_q;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                if (bus.mem_ready) begin
                    case (state_q)
                        S_FETCH:  state_d = S_DECODE;
                        S_MEM_RD: state_d = S_WB;
                        default:  state_d = S_FETCH;
                    endcase
                end else if (timeoutHit) begin
                    state_d = S_HALT;
                end else if (MEM_TIMEOUT != 0) begin
                    waitCnt_d = waitCnt_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    6'h00:   begin state_d = S_EXEC_R; class_d = CL_R;     end
                    6'h08:   begin state_d = S_EXEC_I; class_d = CL_ADDI;  end
                    6'h09:   begin state_d = S_EXEC_I; class_d = CL_ADDIU; end
                    6'h23:   begin state_d = S_ADDR;   class_d = CL_LW;    end
                    6'h2B:   begin state_d = S_ADDR;   class_d = CL_SW;    end
                    6'h04:   begin state_d = S_BRANCH; class_d = CL_BEQ;   end
                    default: state_d = S_HALT;
                endcase
            end
            S_EXEC_R: state_d = functOk ? S_WB : S_HALT;
            S_EXEC_I: state_d = S_WB;
            S_ADDR:   state_d = (class_q == CL_LW) ? S_MEM_RD : S_MEM_WR;
            S_WB:     state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
        if ((state_d != state_q) &&
            (state_d == S_FETCH || state_d == S_MEM_RD || state_d == S_MEM_WR))
            waitCnt_d = '0;
    end

`ifdef CTRL_PERF_CNT_EN
    logic              retireEvt;
    logic [PERF_W-1:0] retired_q;
    assign retireEvt = (state_d == S_FETCH) &&
                       (state_q == S_WB || state_q == S_MEM_WR || state_q == S_BRANCH);
    assign retired   = retired_q;
`endif

    // State, class, wait counter (and optional retired counter) registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RST;
            class_q   <= CL_R;
            waitCnt_q <= '0;
`ifdef CTRL_PERF_CNT_EN
            retired_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            waitCnt_q <= waitCnt_d;
`ifdef CTRL_PERF_CNT_EN
            if (retireEvt)
                retired_q <= retired_q + PERF_W'(1);
`endif
        end
    end

    // Control outputs decoded from state; anything not named in a state is 0
    always_comb begin
        bus.aluControl = 6'h00;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 1'b0;
        bus.ir_write   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_read   = 1'b1;
                bus.alu_src_b  = 2'b01;
                bus.aluControl = 6'h21;
                bus.ir_write   = bus.mem_ready;
                bus.pc_write   = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_b  = 2'b11;
                bus.aluControl = 6'h21;
            end
            S_EXEC_R: begin
                bus.alu_src_a  = 1'b1;
                bus.aluControl = functOk ? bus.funct : 6'h00;
            end
            S_EXEC_I: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.aluControl = (class_q == CL_ADDI) ? 6'h20 : 6'h21;
            end
            S_ADDR: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.aluControl = (class_q == CL_LW) ? 6'h0E : 6'h1E;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            S_WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = (class_q == CL_R);
                bus.mem_to_reg = (class_q == CL_LW);
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.pc_src    = 1'b1;
                bus.pc_write  = bus.isZero;
            end
            S_HALT:  bus.illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed bench for mc_control built with MEM_TIMEOUT=4.
// Walks R-type, addiu, lw with memory waits, both beq outcomes, an sw that
// times out, a reset in the middle of MEM_WR, and both illegal encodings.
module tb_mc_control;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    mc_control_if bus ();

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] retired;
`endif

    mc_control #(.MEM_TIMEOUT(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.master)
`ifdef CTRL_PERF_CNT_EN
        ,
        .retired (retired)
`endif
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [18:0] ctlVec;
    assign ctlVec = {bus.aluControl, bus.alu_src_a, bus.alu_src_b, bus.pc_write,
                     bus.pc_src, bus.ir_write, bus.mem_read, bus.mem_write, bus.iord,
                     bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.illegal};

    // Builds the expected control vector in the same bit order as ctlVec
    function automatic logic [18:0] mk(input logic [5:0] alu, input logic a,
                                       input logic [1:0] b, input logic pcw,
                                       input logic pcs, input logic irw,
                                       input logic mr, input logic mw,
                                       input logic io, input logic rw,
                                       input logic rd, input logic m2r,
                                       input logic ill);
        return {alu, a, b, pcw, pcs, irw, mr, mw, io, rw, rd, m2r, ill};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic rdy);
        bus.opcode    = op;
        bus.funct     = fn;
        bus.isZero    = z;
        bus.mem_ready = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkCtl(input string tag, input logic [18:0] exp);
        checkOutput(tag, {13'b0, ctlVec}, {13'b0, exp});
    endtask

    localparam logic [18:0] E_ZERO     = 19'b0;
    localparam logic [18:0] E_FETCH    = {6'h21, 1'b0, 2'b01, 10'b1_0_1_1_0_0_0_0_0_0};
    localparam logic [18:0] E_FETCHW   = {6'h21, 1'b0, 2'b01, 10'b0_0_0_1_0_0_0_0_0_0};
    localparam logic [18:0] E_DECODE   = {6'h21, 1'b0, 2'b11, 10'b0};
    localparam logic [18:0] E_MEMRD    = {6'h00, 1'b0, 2'b00, 10'b0_0_0_1_0_1_0_0_0_0};
    localparam logic [18:0] E_MEMWR    = {6'h00, 1'b0, 2'b00, 10'b0_0_0_0_1_1_0_0_0_0};
    localparam logic [18:0] E_HALT     = {6'h00, 1'b0, 2'b00, 10'b0_0_0_0_0_0_0_0_0_1};

    // Linear sequence of directed steps
    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        applyStimulus(6'h00, 6'h00, 1'b0, 1'b0);
        #2;
        checkCtl("reset_outputs", E_ZERO);
        #9;
        rst_n = 1'b1;
        #1;
        checkCtl("rst_state", E_ZERO);
`ifdef CTRL_PERF_CNT_EN
        checkOutput("retired_reset", retired, 32'd0);
`endif

        // R-type sub: FETCH, DECODE, EXEC_R, WB, back in FETCH
        tick;
        applyStimulus(6'h00, 6'h22, 1'b0, 1'b1);
        checkCtl("r_fetch", E_FETCH);
        tick;
        checkCtl("r_decode", E_DECODE);
        tick;
        checkCtl("r_exec_sub", mk(6'h22, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick;
        checkCtl("r_wb", mk(6'h00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        tick;

        // addiu with one fetch wait cycle
        applyStimulus(6'h09, 6'h00, 1'b0, 1'b0);
        checkCtl("i_fetch_wait", E_FETCHW);
        tick;
        applyStimulus(6'h09, 6'h00, 1'b0, 1'b1);
        checkCtl("i_fetch_ready", E_FETCH);
        tick;
        checkCtl("i_decode", E_DECODE);
        tick;
        checkCtl("i_exec_addiu", mk(6'h21, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick;
        checkCtl("i_wb", mk(6'h00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tick;

        // lw with mem_ready low 3 cycles in MEM_RD; ready on the 4th beats timeout
        applyStimulus(6'h23, 6'h00, 1'b0, 1'b1);
        checkCtl("lw_fetch", E_FETCH);
        tick;
        tick;
        checkCtl("lw_addr", mk(6'h0E, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(6'h23, 6'h00, 1'b0, 1'b0);
        tick;
        for (int i = 0; i < 3; i++) begin
            checkCtl($sformatf("lw_memrd_wait%0d", i), E_MEMRD);
            tick;
        end
        applyStimulus(6'h23, 6'h00, 1'b0, 1'b1);
        checkCtl("lw_memrd_ready", E_MEMRD);
        tick;
        checkCtl("lw_wb", mk(6'h00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tick;
        checkCtl("lw_back_fetch", E_FETCH);
`ifdef CTRL_PERF_CNT_EN
        checkOutput("retired_3", retired, 32'd3);
`endif

        // beq taken, then isZero dropped in the same BRANCH cycle
        applyStimulus(6'h04, 6'h00, 1'b0, 1'b1);
        tick;
        tick;
        applyStimulus(6'h04, 6'h00, 1'b1, 1'b1);
        checkCtl("beq_taken", mk(6'h00, 1, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(6'h04, 6'h00, 1'b0, 1'b1);
        checkCtl("beq_same_cycle_z0", mk(6'h00, 1, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tick;
        checkCtl("beq1_back_fetch", E_FETCH);

        // beq not taken
        tick;
        tick;
        checkCtl("beq_not_taken", mk(6'h00, 1, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tick;
        checkCtl("beq2_back_fetch", E_FETCH);
`ifdef CTRL_PERF_CNT_EN
        checkOutput("retired_5", retired, 32'd5);
`endif

        // sw that never gets mem_ready: 4 cycles in MEM_WR then HALT
        applyStimulus(6'h2B, 6'h00, 1'b0, 1'b1);
        tick;
        tick;
        checkCtl("sw_addr", mk(6'h1E, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(6'h2B, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick;
            checkCtl($sformatf("sw_memwr_wait%0d", i), E_MEMWR);
        end
        tick;
        checkCtl("sw_timeout_halt", E_HALT);
        applyStimulus(6'h2B, 6'h00, 1'b1, 1'b1);
        tick;
        checkCtl("halt_sticky", E_HALT);
`ifdef CTRL_PERF_CNT_EN
        checkOutput("retired_frozen", retired, 32'd5);
`endif
        rst_n = 1'b0;
        #1;
        checkCtl("halt_reset_async", E_ZERO);
        #2;
        rst_n = 1'b1;
        #1;
        checkCtl("halt_reset_rst", E_ZERO);
`ifdef CTRL_PERF_CNT_EN
        checkOutput("retired_cleared", retired, 32'd0);
`endif
        tick;
        checkCtl("after_halt_fetch", E_FETCH);

        // Reset asserted in the middle of a MEM_WR access
        applyStimulus(6'h2B, 6'h00, 1'b0, 1'b1);
        tick;
        tick;
        applyStimulus(6'h2B, 6'h00, 1'b0, 1'b0);
        tick;
        checkCtl("sw2_memwr", E_MEMWR);
        #2;
        rst_n = 1'b0;
        #1;
        checkCtl("memwr_reset_async", E_ZERO);
        #2;
        rst_n = 1'b1;
        #1;
        checkCtl("memwr_reset_rst", E_ZERO);
        tick;
        checkCtl("memwr_reset_fetch_wait", E_FETCHW);

        // R-type with unsupported funct 0x08
        applyStimulus(6'h00, 6'h08, 1'b0, 1'b1);
        checkCtl("badfunct_fetch", E_FETCH);
        tick;
        tick;
        checkCtl("badfunct_exec", mk(6'h00, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick;
        checkCtl("badfunct_halt", E_HALT);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        checkCtl("badfunct_reset", E_ZERO);
        tick;

        // Unknown opcode 0x3F
        applyStimulus(6'h3F, 6'h20, 1'b0, 1'b1);
        checkCtl("badop_fetch", E_FETCH);
        tick;
        checkCtl("badop_decode", E_DECODE);
        tick;
        checkCtl("badop_halt", E_HALT);
        tick;
        checkCtl("badop_halt_sticky", E_HALT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
